fp_norm_pipe: RTL and testbench

- Pipelined, parametrised normaliser: converts an unnormalised extended value {sign, exponent, wide fixed-point mantissa} into a packed IEEE-style float of configurable exponent/fraction width.
- Successor to the combinational single-precision normaliser. Adds full-sticky rounding, four run-time rounding modes, overflow/underflow/inexact/zero flags, special-value handling, and a 3-stage valid/ready pipeline.
- Sits between the wide accumulator/adder datapath and the result bus.

---
 rtl/fp_norm_pkg.sv | 40 ++++
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_norm_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_norm_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the float normaliser and related datapaths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_norm_pkg;

    // Rounding-mode encodings carried alongside each operand
    localparam logic [1:0] RND_RNE = 2'b00;
    localparam logic [1:0] RND_RTZ = 2'b01;
    localparam logic [1:0] RND_RUP = 2'b10;
    localparam logic [1:0] RND_RDN = 2'b11;

    function automatic int calc_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int calc_in_w(input int exp_w, input int mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    function automatic int calc_out_w(input int exp_w, input int frc_w);
        return 1 + exp_w + frc_w;
    endfunction

    // Width-independent control bits that ride along every pipeline stage
    typedef struct packed {
        logic       sign;
        logic [1:0] rnd;
        logic       mzero;
        logic       espec;
    } ctl_t;

    // Result flags in output order
    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic zero;
    } flags_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for a W-bit vector, with an all-zero indication.
// Latency: purely combinational.
// Backpressure: none (no state).
module fp_lzc #(
    parameter  int W  = 31,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Scan upward so the last hit is the most significant set bit
    always_comb begin
        count    = CW'(W);
        all_zero = (value == '0);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Normalises {sign, exponent, wide mantissa} into a packed float with rounding and flags.
// Latency: 3 cycles accept-to-valid, one operand per cycle.
// Backpressure: all stages advance together on iReady | ~oValid; oReady mirrors that.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int FRC_W  = 23,
    parameter  int MANT_W = 31,
    localparam int IN_W   = calc_in_w(EXP_W, MANT_W),
    localparam int OUT_W  = calc_out_w(EXP_W, FRC_W)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [IN_W-1:0]  iA,
    input  logic [1:0]       iRnd,
    input  logic             iValid,
    output logic             oReady,
    output logic [OUT_W-1:0] oNR,
    output logic             oOvf,
    output logic             oUnf,
    output logic             oInx,
    output logic             oZero,
    output logic             oValid,
    input  logic             iReady
);

    localparam int CW = $clog2(MANT_W + 1);
    localparam int LW = MANT_W + FRC_W;
    // Room for E - L going negative and for the rounding carry
    localparam int EW = ((EXP_W > CW) ? EXP_W : CW) + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [FRC_W-1:0]     QNAN_FRC = {1'b1, {(FRC_W-1){1'b0}}};

    logic en;
    assign en     = iReady | ~oValid;
    assign oReady = en;

    // ---------------- stage 1: leading-zero count ----------------
    logic [CW-1:0] lzc_cnt;
    logic          lzc_zero;

    fp_lzc #(.W(MANT_W)) u_lzc (
        .value    (iA[MANT_W-1:0]),
        .count    (lzc_cnt),
        .all_zero (lzc_zero)
    );

    logic              v1;
    ctl_t              ctl1;
    logic [EXP_W-1:0]  e1;
    logic [MANT_W-1:0] m1;
    logic [CW-1:0]     l1;

    // Capture operand, its rounding mode and the shift distance
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1   <= 1'b0;
            ctl1 <= '0;
            e1   <= '0;
            m1   <= '0;
            l1   <= '0;
        end else if (en) begin
            v1         <= iValid;
            ctl1.sign  <= iA[IN_W-1];
            ctl1.rnd   <= iRnd;
            ctl1.mzero <= lzc_zero;
            ctl1.espec <= (iA[IN_W-2 -: EXP_W] == '1);
            e1         <= iA[IN_W-2 -: EXP_W];
            m1         <= iA[MANT_W-1:0];
            l1         <= lzc_cnt;
        end
    end

    // ---------------- stage 2: shift and round ----------------
    // The hidden one is dropped; only bits below it feed the fraction
    logic [MANT_W-2:0] mn_low;
    logic [LW-1:0]     frac_ext;
    logic [FRC_W-1:0]  frac_raw;
    logic              g_bit;
    logic              s_bit;
    logic              inc;
    logic [FRC_W:0]    frac_sum;

    assign mn_low   = (MANT_W-1)'(m1 << l1);
    assign frac_ext = {mn_low, {(FRC_W+1){1'b0}}};
    assign frac_raw = frac_ext[LW-1 -: FRC_W];
    assign g_bit    = frac_ext[LW-1-FRC_W];
    assign s_bit    = |frac_ext[LW-2-FRC_W:0];
    assign frac_sum = {1'b0, frac_raw} + (FRC_W+1)'(inc);

    // Rounding increment decision for the selected mode
    always_comb begin
        inc = 1'b0;
        case (ctl1.rnd)
            RND_RNE: inc = g_bit & (s_bit | frac_raw[0]);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = ~ctl1.sign & (g_bit | s_bit);
            RND_RDN: inc = ctl1.sign & (g_bit | s_bit);
            default: inc = 1'b0;
        endcase
    end

    logic             v2;
    ctl_t             ctl2;
    logic [EXP_W-1:0] e2;
    logic [CW-1:0]    l2;
    logic [FRC_W-1:0] frac2;
    logic             carry2;
    logic             inx2;

    // Hold the rounded fraction and carry for exponent adjustment
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v2     <= 1'b0;
            ctl2   <= '0;
            e2     <= '0;
            l2     <= '0;
            frac2  <= '0;
            carry2 <= 1'b0;
            inx2   <= 1'b0;
        end else if (en) begin
            v2     <= v1;
            ctl2   <= ctl1;
            e2     <= e1;
            l2     <= l1;
            frac2  <= frac_sum[FRC_W-1:0];
            carry2 <= frac_sum[FRC_W];
            inx2   <= g_bit | s_bit;
        end
    end

    // ---------------- stage 3: exponent and pack ----------------
    logic signed [EW-1:0] ediff;
    logic signed [EW-1:0] eo;
    logic [OUT_W-1:0]     nr_d;
    flags_t               fl_d;
    logic                 to_inf;

    assign ediff  = $signed(EW'(e2)) - $signed(EW'(l2));
    assign eo     = ediff + $signed(EW'(carry2));
    assign to_inf = (ctl2.rnd == RND_RNE) |
                    ((ctl2.rnd == RND_RUP) & ~ctl2.sign) |
                    ((ctl2.rnd == RND_RDN) &  ctl2.sign);

    // Special values first, then zero, underflow, overflow, normal
    always_comb begin
        nr_d = {ctl2.sign, {(OUT_W-1){1'b0}}};
        fl_d = '0;
        if (ctl2.espec) begin
            nr_d = {ctl2.sign, {EXP_W{1'b1}}, ctl2.mzero ? {FRC_W{1'b0}} : QNAN_FRC};
        end else if (ctl2.mzero) begin
            fl_d.zero = 1'b1;
        end else if (ediff <= 0) begin
            fl_d.unf  = 1'b1;
            fl_d.zero = 1'b1;
            fl_d.inx  = 1'b1;
        end else if (eo >= EXP_MAX) begin
            fl_d.ovf = 1'b1;
            fl_d.inx = 1'b1;
            if (to_inf) begin
                nr_d = {ctl2.sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            end else begin
                nr_d = {ctl2.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
            end
        end else begin
            nr_d     = {ctl2.sign, eo[EXP_W-1:0], frac2};
            fl_d.inx = inx2;
        end
    end

    // Output register doubles as the final pipeline stage
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid <= 1'b0;
            oNR    <= '0;
            oOvf   <= 1'b0;
            oUnf   <= 1'b0;
            oInx   <= 1'b0;
            oZero  <= 1'b0;
        end else if (en) begin
            oValid <= v2;
            oNR    <= nr_d;
            oOvf   <= fl_d.ovf;
            oUnf   <= fl_d.unf;
            oInx   <= fl_d.inx;
            oZero  <= fl_d.zero;
        end
    end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe with default parameters.
// Latency: directed checks confirm 3 cycles accept-to-valid.
// Backpressure: random and scripted iReady stalls against a scoreboard.
module tb_fp_norm_pipe;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [39:0] iA;
    logic [1:0]  iRnd;
    logic        iValid;
    logic        oReady;
    logic [31:0] oNR;
    logic        oOvf, oUnf, oInx, oZero;
    logic        oValid;
    logic        iReady;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] nr;
        logic [3:0]  fl;   // {ovf, unf, inx, zero}
    } exp_t;

    exp_t sb[$];

    fp_norm_pipe dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iA     (iA),
        .iRnd   (iRnd),
        .iValid (iValid),
        .oReady (oReady),
        .oNR    (oNR),
        .oOvf   (oOvf),
        .oUnf   (oUnf),
        .oInx   (oInx),
        .oZero  (oZero),
        .oValid (oValid),
        .iReady (iReady)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: value-level rounding with unbounded precision arithmetic
    function automatic exp_t model(input logic [39:0] a, input logic [1:0] r);
        exp_t   res;
        logic   s;
        int     e, p, eu, sh;
        longint m, q, rem, half;
        logic   inexact, up;
        s = a[39];
        e = int'(a[38:31]);
        m = longint'(a[30:0]);
        res.nr = {s, 31'd0};
        res.fl = 4'b0000;
        if (e == 255) begin
            res.nr = {s, 8'hFF, (m == 0) ? 23'h0 : 23'h40_0000};
            return res;
        end
        if (m == 0) begin
            res.fl = 4'b0001;
            return res;
        end
        p = 30;
        while (((m >> p) & 1) == 0) p--;
        eu = e - (30 - p);
        if (eu <= 0) begin
            res.fl = 4'b0111;
            return res;
        end
        sh = p - 23;
        if (sh > 0) begin
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
        end else begin
            q    = m << (-sh);
            rem  = 0;
            half = 1;
        end
        inexact = (rem != 0);
        case (r)
            2'b00:   up = (rem > half) || (rem == half && q[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !s && inexact;
            default: up = s && inexact;
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin
            q  = q >> 1;
            eu = eu + 1;
        end
        if (eu >= 255) begin
            res.fl = 4'b1010;
            if (r == 2'b00 || (r == 2'b10 && !s) || (r == 2'b11 && s))
                res.nr = {s, 8'hFF, 23'h0};
            else
                res.nr = {s, 8'hFE, 23'h7F_FFFF};
        end else begin
            res.nr = {s, 8'(eu), 23'(q)};
            res.fl = {2'b00, inexact, 1'b0};
        end
        return res;
    endfunction

    function automatic logic [39:0] rand_op();
        logic [30:0] m;
        logic [7:0]  e;
        int          k;
        k = $urandom_range(0, 9);
        m = 31'($urandom) >> $urandom_range(0, 30);
        if (k == 0) m = '0;
        if (k == 9) m = ((m | 31'h4000_0000) & ~31'h7F) | 31'h40;
        if (k < 3)      e = 8'($urandom_range(0, 40));
        else if (k < 6) e = 8'($urandom_range(220, 255));
        else            e = 8'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // One cycle: drive at the falling edge, observe, then cross a rising edge
    task automatic step(input logic v, input logic [39:0] a, input logic [1:0] r,
                        input logic rdy, output logic acc);
        exp_t x;
        iValid = v; iA = a; iRnd = r; iReady = rdy;
        #1;
        acc = v && oReady;
        if (oValid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_spurious: observed output %0h expected none", oNR);
            end
            if (sb.size() > 0) begin
                if (!rdy) begin
                    chk("stall_hold_nr", oNR, sb[0].nr);
                    chk("stall_ready", oReady, 0);
                end else begin
                    x = sb.pop_front();
                    chk("sb_nr", oNR, x.nr);
                    chk("sb_flags", {oOvf, oUnf, oInx, oZero}, x.fl);
                end
            end
        end
        if (acc) sb.push_back(model(a, r));
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    // Single operand through an empty pipe with constant expectations
    task automatic directed(input string tag, input logic [39:0] a, input logic [1:0] r,
                            input logic [31:0] enr, input logic [3:0] efl,
                            input logic [3:0] fmask);
        int lat;
        iValid = 1'b1; iA = a; iRnd = r; iReady = 1'b1;
        #1;
        chk({tag, "_ready"}, oReady, 1);
        @(posedge iCLK);
        @(negedge iCLK);
        iValid = 1'b0;
        lat = 1;
        while (!oValid && lat < 8) begin
            @(posedge iCLK);
            @(negedge iCLK);
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_nr"}, oNR, enr);
        chk({tag, "_flags"}, {oOvf, oUnf, oInx, oZero} & fmask, efl & fmask);
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    initial begin
        logic acc;
        int   issued;
        logic [39:0] ops [6];

        iRST = 1'b1; iA = '0; iRnd = 2'b00; iValid = 1'b0; iReady = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("rst_valid", oValid, 0);
        chk("rst_nr", oNR, 0);
        chk("rst_flags", {oOvf, oUnf, oInx, oZero}, 0);
        chk("rst_ready", oReady, 1);
        iRST = 1'b0;
        @(negedge iCLK);

        directed("unit",     {1'b0, 8'd127, 31'h4000_0000}, 2'b00, 32'h3F80_0000, 4'b0000, 4'hF);
        directed("deep",     {1'b0, 8'd157, 31'h0000_0001}, 2'b00, 32'h3F80_0000, 4'b0000, 4'hF);
        directed("rne_up",   {1'b0, 8'd127, 31'h7FFF_FFFF}, 2'b00, 32'h4000_0000, 4'b0010, 4'hF);
        directed("rtz",      {1'b0, 8'd127, 31'h7FFF_FFFF}, 2'b01, 32'h3FFF_FFFF, 4'b0010, 4'hF);
        directed("tie_even", {1'b0, 8'd127, 31'h4000_0040}, 2'b00, 32'h3F80_0000, 4'b0010, 4'hF);
        directed("tie_odd",  {1'b0, 8'd127, 31'h4000_00C0}, 2'b00, 32'h3F80_0002, 4'b0010, 4'hF);
        directed("ovf_rne",  {1'b0, 8'd254, 31'h7FFF_FFFF}, 2'b00, 32'h7F80_0000, 4'b1010, 4'hF);
        directed("ovf_rtz",  {1'b0, 8'd254, 31'h7FFF_FFFF}, 2'b01, 32'h7F7F_FFFF, 4'b0010, 4'b0010);
        directed("neg_rup",  {1'b1, 8'd254, 31'h7FFF_FFFF}, 2'b10, 32'hFF7F_FFFF, 4'b0010, 4'b0010);
        directed("unf",      {1'b1, 8'd5,   31'h0000_0001}, 2'b00, 32'h8000_0000, 4'b0111, 4'hF);
        directed("inf_in",   {1'b0, 8'd255, 31'h0000_0000}, 2'b00, 32'h7F80_0000, 4'b0000, 4'hF);

        // Six back-to-back operands with a five-cycle downstream stall
        for (int i = 0; i < 6; i++) ops[i] = {1'b0, 8'(120 + i), 31'h4000_0000 | 31'(i * 37)};
        issued = 0;
        for (int c = 0; c < 40 && (issued < 6 || sb.size() > 0); c++) begin
            step(issued < 6, (issued < 6) ? ops[issued] : 40'd0, 2'b00,
                 !(c >= 3 && c < 8), acc);
            if (acc) issued++;
        end
        chk("stream_issued", issued, 6);
        chk("stream_drained", sb.size(), 0);

        // Reset while results are in flight
        for (int i = 0; i < 3; i++) step(1'b1, rand_op(), 2'($urandom), 1'b1, acc);
        iValid = 1'b0;
        #2;
        chk("pre_rst_valid", oValid, 1);
        iRST = 1'b1;
        #1;
        chk("mid_rst_valid", oValid, 0);
        chk("mid_rst_ready", oReady, 1);
        sb.delete();
        @(negedge iCLK);
        iRST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 40'd0, 2'b00, 1'b1, acc);
            chk("post_rst_valid", oValid, 0);
        end

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_op(), 2'($urandom),
                 $urandom_range(0, 9) < 7, acc);
        end
        for (int k = 0; k < 20 && sb.size() > 0; k++) step(1'b0, 40'd0, 2'b00, 1'b1, acc);
        chk("final_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
